// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, states and defaults
// for the E-stage multiply/divide unit.
package muldiv_pkg;

  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [31:0] neg_if(
    input logic        n,
    input logic [31:0] v
  );
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2_step.sv
// div_radix2_step: one restoring shift/subtract
// iteration producing a single quotient bit.
module div_radix2_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic        borrow;

  // shift next dividend bit in, trial subtract, restore on borrow
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    borrow  = shifted < {1'b0, dvs_i};
    rem_o   = borrow ? shifted[31:0]
                     : shifted[31:0] - dvs_i;
    quo_o   = {quo_i[30:0], ~borrow};
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: single-cycle MULT/MULTU and
// iterative radix-2 DIV/DIVU with HI/LO results.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic [31:0]   res_lo_q, res_lo_d;

  logic          is_div;
  logic          is_sgn;
  logic          go;
  logic          mul_fire;
  logic          div_fire;
  logic          a_neg;
  logic          b_neg;
  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [63:0]   prod;
  logic [31:0]   step_rem;
  logic [31:0]   step_quo;

  assign is_div = (op_i == OP_DIV)
                | (op_i == OP_DIVU);
  assign is_sgn = (op_i == OP_MULT)
                | (op_i == OP_DIV);
  assign go     = start_i & resetn & ~flush_i
                & (state_q == ST_IDLE);
  assign mul_fire = go & ~is_div;
  assign div_fire = go & is_div;
  assign a_neg  = is_sgn & a_i[31];
  assign b_neg  = is_sgn & b_i[31];

  // sign-extend per op so one 64-bit product serves both
  assign mul_a = {{32{a_neg}}, a_i};
  assign mul_b = {{32{b_neg}}, b_i};
  assign prod  = mul_a * mul_b;

  div_radix2_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (div_fire) begin
          rem_d   = '0;
          quo_d   = neg_if(a_neg, a_i);
          dvs_d   = neg_if(b_neg, b_i);
          // x/0 keeps all-ones quotient unsigned
          qneg_d  = (a_neg ^ b_neg)
                  & (b_i != 32'd0);
          rneg_d  = a_neg;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_CYCLES - 1)) begin
          res_hi_d = neg_if(rneg_q, step_rem);
          res_lo_d = neg_if(qneg_q, step_quo);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush_i) begin
      state_d  = ST_IDLE;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
    end
  end

  // handshake outputs and HI/LO result mux
  always_comb begin
    stall_o        = div_fire
                   | ((state_q == ST_BUSY)
                      & ~flush_i);
    busy_o         = state_q == ST_BUSY;
    result_valid_o = mul_fire
                   | ((state_q == ST_DONE)
                      & ~flush_i);
    hi_o = res_hi_q;
    lo_o = res_lo_q;
    if (mul_fire) begin
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end
  end

  // state, counter and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, number of radix-2 division iterations.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_i  input  1  E-stage mul/div instruction valid.
REQ-005 SHALL have port op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a_i  input  32  rs operand (dividend or multiplicand).
REQ-007 SHALL have port b_i  input  32  rt operand (divisor or multiplier).
REQ-008 SHALL have port flush_i  input  1  exception flush; cancels any operation.
REQ-009 SHALL have port stall_o  output  1  pipeline stall request to the hazard unit's mut_div_stallE input.
REQ-010 SHALL have port busy_o  output  1  division in progress.
REQ-011 SHALL have port result_valid_o  output  1  hi_o/lo_o carry a new result this cycle.
REQ-012 SHALL have port hi_o  output  32  HI result (product high word or remainder).
REQ-013 SHALL have port lo_o  output  32  LO result (product low word or quotient).

Function
REQ-014 SHALL implement states IDLE, BUSY and DONE.
REQ-015 MULT/MULTU, when start_i is high in IDLE: signed or unsigned 64-bit product driven combinationally on hi_o/lo_o with result_valid_o=1 in the same cycle; stall_o=0; state stays IDLE.
REQ-016 DIV/DIVU, when start_i is high in IDLE (cycle T), SHALL:
- assert stall_o combinationally in T;
- latch operand magnitudes and sign flags;
- clear the iteration counter;
- move to BUSY.
REQ-017 In BUSY: one restoring quotient bit per cycle; stall_o=1; busy_o=1; after DIV_CYCLES iterations, move to DONE.
REQ-018 DONE SHALL be reached at T+DIV_CYCLES+1, with stall_o=0 and result_valid_o=1; hi_o holds the remainder and lo_o the quotient, from registers.
REQ-019 DONE SHALL return to IDLE unconditionally after one cycle; start_i in DONE SHALL be ignored, since it belongs to the completing instruction.
REQ-020 Signed division SHALL negate the quotient when the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-021 0x80000000 DIV 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (two's-complement wrap).
REQ-022 Division by zero SHALL run full latency with no exception, giving lo=0xFFFFFFFF and hi=the raw a_i value, for both DIV and DIVU.
REQ-023 flush_i SHALL have priority over start_i in every state:
- gates stall_o and result_valid_o to 0 combinationally;
- forces IDLE at the next edge;
- leaves the result registers unchanged.
REQ-024 Outside result_valid_o cycles, hi_o/lo_o SHALL hold the last division result registers.
REQ-025 A new DIV SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-026 resetn low SHALL asynchronously force:
- state IDLE;
- counter 0;
- all datapath and result registers 0;
- stall_o, busy_o and result_valid_o all 0.
REQ-027 Reset asserted mid-division SHALL abandon the operation; the first start_i after release SHALL begin a fresh operation.

Structure
REQ-028 Op encodings, the state enumeration and the DIV_CYCLES default SHALL live in the shared package muldiv_pkg.
REQ-029 The single-iteration shift/subtract/restore step SHALL be the sub-module div_radix2_step; the multiplier stays inline.

Verification
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 SHALL give stall_o high T..T+32, then at T+33 result_valid_o=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU a=100, b=7 SHALL give lo=0x0000000E, hi=0x00000002 at T+33.
REQ-032 MULT 0xFFFFFFFE x 3 SHALL give hi=0xFFFFFFFF, lo=0xFFFFFFFA, result_valid_o=1 in the same cycle with stall_o=0; MULTU 0xFFFFFFFF x 2 SHALL give hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIV a=0x12345678, b=0 SHALL give lo=0xFFFFFFFF, hi=0x12345678 at T+33.
REQ-034 flush_i pulsed at T+10 of a DIV SHALL give stall_o=0 that cycle, IDLE next cycle, and no result_valid_o; a subsequent DIVU 9/4 SHALL give lo=2, hi=1.
REQ-035 Back-to-back DIVs (second start_i at the IDLE cycle after DONE) SHALL complete with 33 stall cycles each and correct results; resetn dropped at T+5 SHALL clear all outputs immediately.
